// File: rtl/sr_cmd_gen.sv
// Purpose : turns set/clear request pulses into timed, mutually exclusive s/r drive for an sr_ff and checks q.
// Latency : request -> s/r high 1 edge; request -> done HOLD_CYCLES+2 edges.
// Backpr. : no stall; while busy, one request of each kind is held pending and repeats coalesce.
module sr_cmd_gen #(
   parameter int HOLD_CYCLES  = 2,
   parameter int GUARD_CYCLES = 1,
   parameter int SET_PRIORITY = 0
) (
   input  logic clk,
   input  logic rst,
   input  logic set_req,
   input  logic clr_req,
   input  logic err_clr,
   input  logic q_fb,
   output logic s,
   output logic r,
   output logic busy,
   output logic done,
   output logic err
);

   localparam int MAXC = (HOLD_CYCLES > GUARD_CYCLES) ? HOLD_CYCLES : GUARD_CYCLES;
   localparam int CW   = $clog2(MAXC + 1);
   localparam logic [CW-1:0] HOLD_LD  = CW'(HOLD_CYCLES - 1);
   localparam logic [CW-1:0] GUARD_LD = CW'((GUARD_CYCLES > 0) ? (GUARD_CYCLES - 1) : 0);
   localparam logic [CW-1:0] CNT_ONE  = CW'(1);
   localparam logic SET_WINS = (SET_PRIORITY != 0);
   localparam logic NO_GUARD = (GUARD_CYCLES == 0);

   typedef enum logic [1:0] {IDLE, DRIVE, CHECK, GUARD} state_t;

   state_t        state, state_n;
   logic [CW-1:0] cnt, cnt_n;
   logic          tgt, tgt_n;
   logic          pend_set, pend_set_n;
   logic          pend_clr, pend_clr_n;
   logic          s_n, r_n, busy_n, done_n, err_n;

   logic launch_pt;
   logic src_pend;
   logic cand_set, cand_clr;
   logic take_set, take_clr;

   // Arbitration: the edge that leaves GUARD (or CHECK when GUARD is skipped) acts
   // like an IDLE edge so queued work keeps the minimum GUARD_CYCLES+1 gap.
   always_comb begin
      launch_pt = (state == IDLE)
               || (state == GUARD && cnt == '0)
               || (state == CHECK && NO_GUARD);
      src_pend  = pend_set | pend_clr;
      cand_set  = src_pend ? pend_set : set_req;
      cand_clr  = src_pend ? pend_clr : clr_req;
      take_set  = launch_pt & cand_set & (~cand_clr | SET_WINS);
      take_clr  = launch_pt & cand_clr & ~take_set;
   end

   // Next-state and next-output logic; outputs are all registered below.
   always_comb begin
      state_n    = state;
      cnt_n      = cnt;
      tgt_n      = tgt;
      s_n        = s;
      r_n        = r;
      done_n     = 1'b0;
      err_n      = err & ~err_clr;
      pend_set_n = pend_set | ((state != IDLE) & set_req);
      pend_clr_n = pend_clr | ((state != IDLE) & clr_req);

      case (state)
         IDLE: begin
            state_n = IDLE;
         end
         DRIVE: begin
            if (cnt == '0) begin
               s_n     = 1'b0;
               r_n     = 1'b0;
               state_n = CHECK;
            end else begin
               cnt_n = cnt - CNT_ONE;
            end
         end
         CHECK: begin
            done_n = 1'b1;
            if (q_fb != tgt) err_n = 1'b1;
            if (NO_GUARD) begin
               state_n = IDLE;
            end else begin
               state_n = GUARD;
               cnt_n   = GUARD_LD;
            end
         end
         GUARD: begin
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - CNT_ONE;
         end
         default: state_n = IDLE;
      endcase

      // A chosen command overrides the hand-back to IDLE and starts driving at once.
      if (take_set | take_clr) begin
         state_n    = DRIVE;
         cnt_n      = HOLD_LD;
         s_n        = take_set;
         r_n        = take_clr;
         tgt_n      = take_set;
         pend_set_n = (cand_set & ~take_set) | (src_pend & set_req);
         pend_clr_n = (cand_clr & ~take_clr) | (src_pend & clr_req);
      end

      busy_n = (state_n != IDLE);
   end

   // State, counter, pending bits and registered outputs; reset drops any command in flight.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state    <= IDLE;
         cnt      <= '0;
         tgt      <= 1'b0;
         pend_set <= 1'b0;
         pend_clr <= 1'b0;
         s        <= 1'b0;
         r        <= 1'b0;
         busy     <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         state    <= state_n;
         cnt      <= cnt_n;
         tgt      <= tgt_n;
         pend_set <= pend_set_n;
         pend_clr <= pend_clr_n;
         s        <= s_n;
         r        <= r_n;
         busy     <= busy_n;
         done     <= done_n;
         err      <= err_n;
      end
   end

endmodule
